// File: rtl/pwd_lock_ctrl.sv
// Keypad password lock: 4-digit BCD entry from four debounced buttons,
// unlock/relock, password change while open, and timed alarm lockout.
module pwd_lock_ctrl #(
    parameter logic [15:0] PWD_DEFAULT   = 16'h1234,
    parameter int          MAX_ERR       = 3,
    parameter int          LOCKOUT_TICKS = 1000
) (
    input  logic       myclk,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic       unlocked,
    output logic       alarm,
    output logic [2:0] state,
    output logic [1:0] digit_idx,
    output logic [3:0] cur_digit,
    output logic [1:0] err_cnt
);
    typedef enum logic [2:0] {
        ENTRY  = 3'd0,
        CHECK  = 3'd1,
        OPEN   = 3'd2,
        SETPWD = 3'd3,
        ALARM  = 3'd4
    } st_t;

    localparam logic [1:0]  MAX_ERR_L = 2'(MAX_ERR);
    localparam logic [15:0] LOCK_LOAD = 16'(LOCKOUT_TICKS - 1);

    st_t             st;
    logic [3:0]      btn_q;
    logic [3:0]      press;
    logic            one_press;
    logic [3:0][3:0] entry;
    logic [3:0][3:0] entry_fin;
    logic [15:0]     pwd;
    logic [15:0]     lock_cnt;
    logic [1:0]      slot;
    logic [1:0]      err_inc;
    logic [1:0]      idx_inc;
    logic [3:0]      cur_inc;

    assign state     = st;
    assign press     = btn & ~btn_q;
    assign one_press = $onehot(press);
    // Digit 0 is typed first and lands in the top nibble, so slot = 3 - idx.
    assign slot      = ~digit_idx;
    assign err_inc   = err_cnt + 2'd1;
    assign idx_inc   = (digit_idx == 2'd3) ? 2'd3 : digit_idx + 2'd1;
    assign cur_inc   = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;

    always_comb begin
        entry_fin       = entry;
        entry_fin[slot] = cur_digit;
    end

    always_ff @(posedge myclk or posedge rst) begin
        if (rst) begin
            st        <= ENTRY;
            btn_q     <= 4'b1111;
            pwd       <= PWD_DEFAULT;
            entry     <= '0;
            digit_idx <= 2'd0;
            cur_digit <= 4'd0;
            err_cnt   <= 2'd0;
            lock_cnt  <= 16'd0;
            unlocked  <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            btn_q <= btn;
            case (st)
                ENTRY, SETPWD: begin
                    if (one_press) begin
                        if (press[0]) begin
                            cur_digit <= cur_inc;
                        end else if (press[1]) begin
                            entry[slot] <= cur_digit;
                            cur_digit   <= 4'd0;
                            digit_idx   <= idx_inc;
                        end else if (press[2]) begin
                            entry <= entry_fin;
                            if (st == ENTRY) begin
                                st <= CHECK;
                            end else begin
                                pwd <= entry_fin;
                                st  <= OPEN;
                            end
                        end else if (st == ENTRY) begin
                            entry     <= '0;
                            digit_idx <= 2'd0;
                            cur_digit <= 4'd0;
                        end else begin
                            st <= OPEN;
                        end
                    end
                end
                CHECK: begin
                    if (entry == pwd) begin
                        st       <= OPEN;
                        unlocked <= 1'b1;
                        err_cnt  <= 2'd0;
                    end else begin
                        err_cnt <= err_inc;
                        if (err_inc == MAX_ERR_L) begin
                            st       <= ALARM;
                            alarm    <= 1'b1;
                            lock_cnt <= LOCK_LOAD;
                        end else begin
                            st        <= ENTRY;
                            entry     <= '0;
                            digit_idx <= 2'd0;
                            cur_digit <= 4'd0;
                        end
                    end
                end
                OPEN: begin
                    if (one_press && (press[2] || press[3])) begin
                        st        <= press[2] ? ENTRY : SETPWD;
                        unlocked  <= press[3];
                        entry     <= '0;
                        digit_idx <= 2'd0;
                        cur_digit <= 4'd0;
                    end
                end
                ALARM: begin
                    if (lock_cnt == 16'd0) begin
                        st        <= ENTRY;
                        alarm     <= 1'b0;
                        err_cnt   <= 2'd0;
                        entry     <= '0;
                        digit_idx <= 2'd0;
                        cur_digit <= 4'd0;
                    end else begin
                        lock_cnt <= lock_cnt - 16'd1;
                    end
                end
                default: begin
                    st        <= ENTRY;
                    unlocked  <= 1'b0;
                    alarm     <= 1'b0;
                    entry     <= '0;
                    digit_idx <= 2'd0;
                    cur_digit <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pwd_lock_ctrl.sv
// Directed bench for pwd_lock_ctrl: entry, wrap, held buttons, unlock,
// alarm lockout timing, password change and mid-operation reset.
module tb_pwd_lock_ctrl;
    localparam int LT = 20;

    logic       myclk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       unlocked, alarm;
    logic [2:0] state;
    logic [1:0] digit_idx, err_cnt;
    logic [3:0] cur_digit;

    int checks = 0;
    int errors = 0;

    pwd_lock_ctrl #(.PWD_DEFAULT(16'h1234), .MAX_ERR(3), .LOCKOUT_TICKS(LT)) dut (
        .myclk(myclk), .rst(rst), .btn(btn), .unlocked(unlocked), .alarm(alarm),
        .state(state), .digit_idx(digit_idx), .cur_digit(cur_digit), .err_cnt(err_cnt)
    );

    always #5 myclk = ~myclk;

    // One clean press: rise at a negedge, release at the next; returns at a negedge.
    task automatic press(input int b);
        @(negedge myclk);
        btn[b] = 1'b1;
        @(negedge myclk);
        btn[b] = 1'b0;
    endtask

    // Types a 4-digit code; the enter press is left to the caller.
    task automatic type_code(input logic [15:0] code);
        logic [3:0] d;
        for (int i = 0; i < 4; i++) begin
            d = code[15 - 4*i -: 4];
            for (int k = 0; k < int'(d); k++) press(0);
            if (i < 3) press(1);
        end
    endtask

    task automatic test_reset;
        btn = 4'b0000;
        rst = 1'b1;
        repeat (2) @(negedge myclk);
        checks++;
        if ({state, unlocked, alarm, err_cnt, digit_idx, cur_digit} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got st=%0d unl=%0b alm=%0b err=%0d idx=%0d cur=%0d want all 0",
                     state, unlocked, alarm, err_cnt, digit_idx, cur_digit);
        end
        rst = 1'b0;
        @(negedge myclk);
    endtask

    task automatic test_digit_wrap;
        repeat (3) press(0);
        checks++;
        if (cur_digit !== 4'd3) begin
            errors++; $display("FAIL inc3: got %0d want 3", cur_digit);
        end
        @(negedge myclk);
        btn = 4'b0011;
        @(negedge myclk);
        btn = 4'b0000;
        @(negedge myclk);
        checks++;
        if ({digit_idx, cur_digit} !== {2'd0, 4'd3}) begin
            errors++; $display("FAIL multi_press: got idx=%0d cur=%0d want idx=0 cur=3", digit_idx, cur_digit);
        end
        repeat (7) press(0);
        checks++;
        if (cur_digit !== 4'd0) begin
            errors++; $display("FAIL wrap9to0: got %0d want 0", cur_digit);
        end
        press(0);
        press(1);
        press(0);
        press(3);
        checks++;
        if ({state, digit_idx, cur_digit} !== 9'd0) begin
            errors++; $display("FAIL clear: got st=%0d idx=%0d cur=%0d want 0", state, digit_idx, cur_digit);
        end
    endtask

    task automatic test_held;
        @(negedge myclk);
        btn[0] = 1'b1;
        repeat (50) @(negedge myclk);
        btn[0] = 1'b0;
        @(negedge myclk);
        checks++;
        if (cur_digit !== 4'd1) begin
            errors++; $display("FAIL held50: got %0d want 1", cur_digit);
        end
        btn[0] = 1'b1;
        rst = 1'b1;
        @(negedge myclk);
        rst = 1'b0;
        repeat (5) @(negedge myclk);
        checks++;
        if (cur_digit !== 4'd0) begin
            errors++; $display("FAIL held_through_rst: got %0d want 0", cur_digit);
        end
        btn[0] = 1'b0;
        @(negedge myclk);
    endtask

    task automatic test_unlock;
        type_code(16'h1234);
        press(2);
        checks++;
        if (state !== 3'd1) begin
            errors++; $display("FAIL check_cycle: got st=%0d want 1", state);
        end
        @(negedge myclk);
        checks++;
        if ({state, unlocked, err_cnt} !== {3'd2, 1'b1, 2'd0}) begin
            errors++; $display("FAIL unlock: got st=%0d unl=%0b err=%0d want 2 1 0", state, unlocked, err_cnt);
        end
        press(0);
        checks++;
        if (state !== 3'd2) begin
            errors++; $display("FAIL open_ignore: got st=%0d want 2", state);
        end
        press(2);
        checks++;
        if ({state, unlocked} !== {3'd0, 1'b0}) begin
            errors++; $display("FAIL relock: got st=%0d unl=%0b want 0 0", state, unlocked);
        end
    endtask

    task automatic test_alarm;
        int n;
        for (int a = 1; a <= 2; a++) begin
            type_code(16'h1235);
            press(2);
            @(negedge myclk);
            checks++;
            if ({state, err_cnt} !== {3'd0, 2'(a)}) begin
                errors++; $display("FAIL wrong%0d: got st=%0d err=%0d want 0 %0d", a, state, err_cnt, a);
            end
        end
        type_code(16'h1235);
        press(2);
        @(negedge myclk);
        checks++;
        if ({state, alarm} !== {3'd4, 1'b1}) begin
            errors++; $display("FAIL alarm_enter: got st=%0d alm=%0b want 4 1", state, alarm);
        end
        n = 0;
        while (state == 3'd4 && n < 200) begin
            if (n == 3) begin
                btn = 4'b0001;
            end else begin
                btn = 4'b0000;
            end
            n++;
            @(negedge myclk);
        end
        checks++;
        if (n !== LT) begin
            errors++; $display("FAIL alarm_dwell: got %0d cycles want %0d", n, LT);
        end
        checks++;
        if ({state, alarm, err_cnt, cur_digit} !== 10'd0) begin
            errors++; $display("FAIL alarm_exit: got st=%0d alm=%0b err=%0d cur=%0d want 0", state, alarm, err_cnt, cur_digit);
        end
    endtask

    task automatic test_change_pwd;
        type_code(16'h1234);
        press(2);
        @(negedge myclk);
        press(3);
        checks++;
        if ({state, unlocked} !== {3'd3, 1'b1}) begin
            errors++; $display("FAIL setpwd_enter: got st=%0d unl=%0b want 3 1", state, unlocked);
        end
        type_code(16'h9876);
        press(2);
        checks++;
        if (state !== 3'd2) begin
            errors++; $display("FAIL setpwd_commit: got st=%0d want 2", state);
        end
        press(2);
        type_code(16'h1234);
        press(2);
        @(negedge myclk);
        checks++;
        if ({state, err_cnt} !== {3'd0, 2'd1}) begin
            errors++; $display("FAIL old_pwd: got st=%0d err=%0d want 0 1", state, err_cnt);
        end
        type_code(16'h9876);
        press(2);
        @(negedge myclk);
        checks++;
        if ({state, unlocked, err_cnt} !== {3'd2, 1'b1, 2'd0}) begin
            errors++; $display("FAIL new_pwd: got st=%0d unl=%0b err=%0d want 2 1 0", state, unlocked, err_cnt);
        end
        press(3);
        type_code(16'h5555);
        press(3);
        press(2);
        type_code(16'h9876);
        press(2);
        @(negedge myclk);
        checks++;
        if (state !== 3'd2) begin
            errors++; $display("FAIL setpwd_cancel: got st=%0d want 2", state);
        end
    endtask

    task automatic test_reset_mid;
        press(3);
        type_code(16'h4321);
        @(negedge myclk);
        rst = 1'b1;
        #1;
        checks++;
        if ({state, unlocked, alarm, err_cnt} !== 7'd0) begin
            errors++; $display("FAIL rst_setpwd: got st=%0d unl=%0b alm=%0b err=%0d want 0", state, unlocked, alarm, err_cnt);
        end
        @(negedge myclk);
        rst = 1'b0;
        type_code(16'h1234);
        press(2);
        @(negedge myclk);
        checks++;
        if (state !== 3'd2) begin
            errors++; $display("FAIL pwd_reverted: got st=%0d want 2", state);
        end
        press(2);
        repeat (3) begin
            type_code(16'h0000);
            press(2);
            @(negedge myclk);
        end
        repeat (4) @(negedge myclk);
        checks++;
        if (state !== 3'd4) begin
            errors++; $display("FAIL alarm_again: got st=%0d want 4", state);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({state, alarm, err_cnt} !== 6'd0) begin
            errors++; $display("FAIL rst_alarm: got st=%0d alm=%0b err=%0d want 0", state, alarm, err_cnt);
        end
        @(negedge myclk);
        rst = 1'b0;
        @(negedge myclk);
    endtask

    initial begin
        test_reset;
        test_digit_wrap;
        test_held;
        test_unlock;
        test_alarm;
        test_change_pwd;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
